// File: rtl/usb_rx_line_decoder_if.sv
// Line-side bundle for the USB full-speed receive front end.
// The raw D+/D- pair flows from the line (master) into the decoder (slave).
// The decoded strobes flow back to the consumer.
//
// Strobe semantics: there is no valid/ready handshake. Each of bit_valid,
// bit_stuffed, stuff_err, line_err and eop is a single-cycle pulse that the
// consumer must take in that cycle, because it cannot apply backpressure.
// At most one of these pulses is high in any cycle. bit_data is meaningful
// only while bit_valid is high; between strobes it holds its last value.
interface usb_rx_line_decoder_if;
    logic d_plus;
    logic d_minus;
    logic bit_valid;
    logic bit_data;
    logic bit_stuffed;
    logic stuff_err;
    logic line_err;
    logic eop;

    modport master (
        output d_plus,
        output d_minus,
        input  bit_valid,
        input  bit_data,
        input  bit_stuffed,
        input  stuff_err,
        input  line_err,
        input  eop
    );

    modport slave (
        input  d_plus,
        input  d_minus,
        output bit_valid,
        output bit_data,
        output bit_stuffed,
        output stuff_err,
        output line_err,
        output eop
    );
endinterface

// File: rtl/usb_rx_line_decoder.sv
// USB full-speed receive line front end.
// The block synchronises D+/D-, recovers bit timing from line transitions and
// NRZI-decodes the samples. It strips stuffed zeros and detects EOP
// (SE0 for at least EOP_SE0_BITS samples, followed by J). Every result leaves
// as a registered one-cycle strobe in the cycle after the sample point.
module usb_rx_line_decoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LEN    = 6,
    parameter int EOP_SE0_BITS = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  n_rst,
    usb_rx_line_decoder_if.slave  line_if,
    output logic                  fsm_state_o   // debug: 0 = RUN, 1 = SE0
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam int SW = $clog2(EOP_SE0_BITS + 1);

    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] SAMPLE_PT  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [OW-1:0] STUFF_MAX  = OW'(STUFF_LEN);
    localparam logic [SW-1:0] SE0_MAX    = SW'(EOP_SE0_BITS);

    // Line state encoding is {D+, D-}.
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SE0 = 1'b1
    } state_e;

    // Synchroniser chains. They reset to idle J so that a reset looks like an idle bus.
    logic [SYNC_STAGES-1:0] dp_sync_q;
    logic [SYNC_STAGES-1:0] dm_sync_q;
    logic [1:0]             line_now;
    logic [1:0]             line_last_q;

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          sample;

    state_e        state_q,  state_d;
    logic [1:0]    prev_q,   prev_d;
    logic [OW-1:0] ones_q,   ones_d;
    logic [SW-1:0] se0_q,    se0_d;

    logic bit_valid_q,   bit_valid_d;
    logic bit_data_q,    bit_data_d;
    logic bit_stuffed_q, bit_stuffed_d;
    logic stuff_err_q,   stuff_err_d;
    logic line_err_q,    line_err_d;
    logic eop_q,         eop_d;

    logic do_decode;
    logic dec_bit;

    // Shift the raw line pair through the synchroniser flops.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_sync_q <= '1;
            dm_sync_q <= '0;
        end else begin
            dp_sync_q <= {dp_sync_q[SYNC_STAGES-2:0], line_if.d_plus};
            dm_sync_q <= {dm_sync_q[SYNC_STAGES-2:0], line_if.d_minus};
        end
    end

    assign line_now = {dp_sync_q[SYNC_STAGES-1], dm_sync_q[SYNC_STAGES-1]};

    // Any change of the synced line state re-centres the bit timer. Without a
    // change, the timer free-runs so that long runs without transitions still
    // yield one sample per bit.
    always_comb begin
        timer_d = timer_q + TW'(1);
        if (line_now != line_last_q) begin
            timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
            timer_d = '0;
        end
    end

    assign sample = (timer_q == SAMPLE_PT);

    // Register the bit timer and the previous clock's synced line state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timer_q     <= '0;
            line_last_q <= LS_J;
        end else begin
            timer_q     <= timer_d;
            line_last_q <= line_now;
        end
    end

    // Decoder FSM next state, counters and strobes. Everything happens only at sample points.
    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        ones_d        = ones_q;
        se0_d         = se0_q;
        bit_valid_d   = 1'b0;
        bit_data_d    = bit_data_q;
        bit_stuffed_d = 1'b0;
        stuff_err_d   = 1'b0;
        line_err_d    = 1'b0;
        eop_d         = 1'b0;
        do_decode     = 1'b0;
        dec_bit       = 1'b0;

        if (sample) begin
            case (state_q)
                ST_RUN: begin
                    case (line_now)
                        LS_J, LS_K: do_decode = 1'b1;
                        LS_SE0: begin
                            se0_d   = SW'(1);
                            state_d = ST_SE0;
                        end
                        default: line_err_d = 1'b1;   // SE1: flag only, touch nothing else
                    endcase
                end
                ST_SE0: begin
                    case (line_now)
                        LS_SE0: begin
                            if (se0_q < SE0_MAX) begin
                                se0_d = se0_q + SW'(1);
                            end
                        end
                        LS_J: begin
                            se0_d   = '0;
                            state_d = ST_RUN;
                            if (se0_q >= SE0_MAX) begin
                                eop_d  = 1'b1;
                                prev_d = LS_J;
                                ones_d = '0;
                            end else begin
                                // SE0 was too short to be an EOP, so this J is an ordinary bit.
                                do_decode = 1'b1;
                            end
                        end
                        LS_K: begin
                            se0_d     = '0;
                            state_d   = ST_RUN;
                            do_decode = 1'b1;
                        end
                        default: line_err_d = 1'b1;   // SE1: stay put, count unchanged
                    endcase
                end
                default: state_d = ST_RUN;
            endcase
        end

        // NRZI: a 1 is "no transition" against the last J/K sample.
        if (do_decode) begin
            dec_bit = (line_now == prev_q);
            prev_d  = line_now;
            if (ones_q == STUFF_MAX) begin
                ones_d = '0;
                if (dec_bit) begin
                    stuff_err_d = 1'b1;
                end else begin
                    bit_stuffed_d = 1'b1;
                end
            end else begin
                bit_valid_d = 1'b1;
                bit_data_d  = dec_bit;
                ones_d      = dec_bit ? ones_q + OW'(1) : '0;
            end
        end
    end

    // Register the FSM state, the decode history and the output strobes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= ST_RUN;
            prev_q        <= LS_J;
            ones_q        <= '0;
            se0_q         <= '0;
            bit_valid_q   <= 1'b0;
            bit_data_q    <= 1'b0;
            bit_stuffed_q <= 1'b0;
            stuff_err_q   <= 1'b0;
            line_err_q    <= 1'b0;
            eop_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            ones_q        <= ones_d;
            se0_q         <= se0_d;
            bit_valid_q   <= bit_valid_d;
            bit_data_q    <= bit_data_d;
            bit_stuffed_q <= bit_stuffed_d;
            stuff_err_q   <= stuff_err_d;
            line_err_q    <= line_err_d;
            eop_q         <= eop_d;
        end
    end

    assign line_if.bit_valid   = bit_valid_q;
    assign line_if.bit_data    = bit_data_q;
    assign line_if.bit_stuffed = bit_stuffed_q;
    assign line_if.stuff_err   = stuff_err_q;
    assign line_if.line_err    = line_err_q;
    assign line_if.eop         = eop_q;
    assign fsm_state_o         = state_q;

endmodule

// File: tb/tb_usb_rx_line_decoder.sv
// Bench for usb_rx_line_decoder with CLKS_PER_BIT=8, STUFF_LEN=6, EOP_SE0_BITS=2, SYNC_STAGES=2.
// A table of line segments {line state, clocks, expected strobe events} drives the DUT.
// A negedge monitor pops each observed strobe off exp_q and compares it.
// Reset behaviour and edge-to-strobe latency get hand-written sequences.
module tb_usb_rx_line_decoder;

    localparam int CPB  = 8;
    localparam int SLEN = 6;
    localparam int EOPN = 2;
    localparam int SYNC = 2;

    localparam logic [1:0] LSE0 = 2'b00;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LSE1 = 2'b11;

    // Event codes seen by the scoreboard.
    localparam logic [2:0] C_B0   = 3'd0;
    localparam logic [2:0] C_B1   = 3'd1;
    localparam logic [2:0] C_STF  = 3'd2;
    localparam logic [2:0] C_SERR = 3'd3;
    localparam logic [2:0] C_LERR = 3'd4;
    localparam logic [2:0] C_EOP  = 3'd5;

    typedef struct {
        logic [1:0]  line;   // line state to drive
        int          clks;   // duration; 0 marks "end scenario and reset"
        int          n;      // number of strobes expected from this segment
        logic [2:0]  code;   // expected event code for each of them
    } seg_t;

    logic clk;
    logic n_rst;
    logic fsm_state;
    int   checks;
    int   errors;
    logic [2:0] exp_q[$];
    seg_t tbl[$];

    usb_rx_line_decoder_if line_if();

    usb_rx_line_decoder #(
        .CLKS_PER_BIT(CPB),
        .STUFF_LEN(SLEN),
        .EOP_SE0_BITS(EOPN),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .line_if(line_if.slave),
        .fsm_state_o(fsm_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: compare every observed strobe with the head of the expected queue.
    always @(negedge clk) begin
        logic [5:0] stb;
        logic [2:0] got;
        logic [2:0] exp;
        if (n_rst) begin
            stb = {line_if.bit_valid, line_if.bit_stuffed, line_if.stuff_err,
                   line_if.line_err, line_if.eop, 1'b0};
            if ($countones(stb) > 1) begin
                checks++;
                errors++;
                $display("FAIL onehot: strobes=%b required at most one at %0t", stb[5:1], $time);
            end
            if (stb != 6'd0) begin
                if (line_if.bit_valid)        got = line_if.bit_data ? C_B1 : C_B0;
                else if (line_if.bit_stuffed) got = C_STF;
                else if (line_if.stuff_err)   got = C_SERR;
                else if (line_if.line_err)    got = C_LERR;
                else                          got = C_EOP;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL event: got code %0d, expected none at %0t", got, $time);
                end else begin
                    exp = exp_q.pop_front();
                    if (got != exp) begin
                        errors++;
                        $display("FAIL event: got code %0d, expected %0d at %0t", got, exp, $time);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] line, input int clks);
        line_if.d_plus  = line[1];
        line_if.d_minus = line[0];
        repeat (clks) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_drain();
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        drive(LJ, 3);
        n_rst = 1'b1;
    endtask

    function automatic void add(input logic [1:0] line, input int clks, input int n,
                                input logic [2:0] code);
        seg_t s;
        s.line = line;
        s.clks = clks;
        s.n    = n;
        s.code = code;
        tbl.push_back(s);
    endfunction

    function automatic void add_rep(input logic [1:0] line, input int cnt, input logic [2:0] code);
        for (int i = 0; i < cnt; i++) add(line, CPB, 1, code);
    endfunction

    initial begin
        int lat;
        checks = 0;
        errors = 0;
        n_rst  = 1'b0;
        line_if.d_plus  = 1'b1;
        line_if.d_minus = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {line_if.bit_valid, line_if.bit_data, line_if.bit_stuffed,
                              line_if.stuff_err, line_if.line_err, line_if.eop}, 0);
        chk("reset_state", fsm_state, 0);

        // Reset mid-packet while the line toggles; then idle J yields plain 1 bits.
        do_reset();
        exp_q.push_back(C_B0);
        drive(LK, CPB);
        drive(LSE0, CPB);
        chk("se0_state", fsm_state, 1);
        n_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive((i % 2 == 0) ? LK : LJ, 1);
            chk("rst_hold_outputs", {line_if.bit_valid, line_if.bit_stuffed, line_if.stuff_err,
                                     line_if.line_err, line_if.eop}, 0);
            chk("rst_hold_state", fsm_state, 0);
        end
        line_if.d_plus  = 1'b1;
        line_if.d_minus = 1'b0;
        n_rst = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(C_B1);
        drive(LJ, 40);
        check_drain();

        // Edge to strobe latency: SYNC_STAGES + CLKS_PER_BIT/2 + 1 clocks.
        do_reset();
        exp_q.push_back(C_B0);
        line_if.d_plus  = 1'b0;
        line_if.d_minus = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (line_if.bit_valid) lat = i;
        end
        chk("latency", lat, SYNC + CPB / 2 + 1);
        if (lat != 0 && lat < CPB) drive(LK, CPB - lat);

        // Table: 0-clock entries close a scenario and reset the DUT.
        add(LJ, 0, 0, C_B0);
        // NRZI SYNC pattern KJKJKJKK -> 0000 0001
        add(LK, CPB, 1, C_B0); add(LJ, CPB, 1, C_B0); add(LK, CPB, 1, C_B0); add(LJ, CPB, 1, C_B0);
        add(LK, CPB, 1, C_B0); add(LJ, CPB, 1, C_B0); add(LK, CPB, 1, C_B0); add(LK, CPB, 1, C_B1);
        add(LJ, 0, 0, C_B0);
        // Stuffing: six 1s then a transition is stuffed; six 1s then a seventh 1 is an error.
        add(LK, CPB, 1, C_B0);
        add_rep(LK, 6, C_B1);
        add(LJ, CPB, 1, C_STF);
        add(LK, CPB, 1, C_B0);
        add_rep(LK, 6, C_B1);
        add(LK, CPB, 1, C_SERR);
        add(LK, CPB, 1, C_B1);
        add(LJ, 0, 0, C_B0);
        // EOP: two SE0 samples then J; one SE0 sample then J/K decodes normally.
        add(LK, CPB, 1, C_B0); add(LJ, CPB, 1, C_B0); add(LK, CPB, 1, C_B0);
        add(LSE0, 2 * CPB, 0, C_B0);
        add(LJ, CPB, 1, C_EOP);
        add(LJ, CPB, 1, C_B1);
        add(LSE0, CPB, 0, C_B0);
        add(LJ, CPB, 1, C_B1);
        add(LSE0, CPB, 0, C_B0);
        add(LK, CPB, 1, C_B0);
        add(LK, CPB, 1, C_B1);
        add(LJ, 0, 0, C_B0);
        // Jitter: bit periods alternate 7 and 9 clocks.
        add(LK, 7, 1, C_B0); add(LJ, 9, 1, C_B0); add(LK, 7, 1, C_B0); add(LJ, 9, 1, C_B0);
        add(LK, 7, 1, C_B0); add(LJ, 9, 1, C_B0); add(LK, CPB, 1, C_B0);
        add(LJ, 0, 0, C_B0);
        // SE1 glitches in RUN and in SE0.
        add(LK, CPB, 1, C_B0);
        add(LSE1, CPB, 1, C_LERR);
        add(LK, CPB, 1, C_B1);
        add(LJ, CPB, 1, C_B0);
        add(LSE0, CPB, 0, C_B0);
        add(LSE1, CPB, 1, C_LERR);
        add(LSE0, CPB, 0, C_B0);
        add(LJ, CPB, 1, C_EOP);
        add(LK, CPB, 1, C_B0);
        add(LJ, 0, 0, C_B0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].clks == 0) begin
                check_drain();
                do_reset();
            end else begin
                for (int k = 0; k < tbl[i].n; k++) exp_q.push_back(tbl[i].code);
                drive(tbl[i].line, tbl[i].clks);
            end
        end
        check_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
